// File: rtl/fp4_e2m1_pkg.sv
// Shared types and constants for the FP4 (E2M1) block quantizer.
package fp4_e2m1_pkg;

    // One E2M1 code: {sign, exp[1:0], man}.
    typedef struct packed {
        logic       sign;
        logic [1:0] exp;
        logic       man;
    } fp4_e2m1_t;

    // Largest unbiased exponent representable in E2M1 (6.0 = 1.5 * 2^2).
    localparam int         E2M1_EMAX       = 2;
    localparam logic [7:0] E8M0_BIAS       = 8'd127;
    // Scale reported for an all-zero block (2^0).
    localparam logic [7:0] E8M0_ZERO_BLOCK = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_SCALE,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/fp4_e2m1_encode.sv
// Combinational E2M1 encoder: scales |x| by 2^-X, rounds to the E2M1 grid
// (ties to the code with man=0) and saturates to 6.0.
module fp4_e2m1_encode
    import fp4_e2m1_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int XW   = 6
) (
    input  logic [IN_W-1:0]       mag,
    input  logic                  sign,
    input  logic signed [XW-1:0]  x,
    output fp4_e2m1_t             code
);

    // Working value carries four fraction bits below the magnitude LSB.
    localparam int WW = IN_W + 4;

    logic [WW-1:0] wide;
    logic [WW-1:0] q4;
    logic [WW-1:0] lost_mask;
    logic          sticky;
    logic          round_up;
    logic [2:0]    mag_code;
    int            sh;
    int            sh_u;

    // q4 = |x| * 2^-X in units of 0.25, plus a sticky bit for anything lower.
    // Each binade then has its own grid step: 0.5 below 2, 1 below 4, 2 above.
    always_comb begin
        wide      = {mag, 4'b0000};
        sh        = int'(x) + 2;
        sh_u      = (sh < 0) ? 0 : sh;
        q4        = wide >> sh_u;
        lost_mask = ~({WW{1'b1}} << sh_u);
        sticky    = |(wide & lost_mask);
        round_up  = 1'b0;
        mag_code  = 3'd0;
        if ((sh < 0 && mag != '0) || q4 >= WW'(24)) begin
            mag_code = 3'd7;
        end else if (q4 < WW'(8)) begin
            round_up = q4[0] & (sticky | q4[1]);
            mag_code = {1'b0, q4[2:1]} + {2'b00, round_up};
        end else if (q4 < WW'(16)) begin
            round_up = q4[1] & (q4[0] | sticky | q4[2]);
            mag_code = {2'b10, q4[2]} + {2'b00, round_up};
        end else begin
            round_up = q4[2] & ((|q4[1:0]) | sticky);
            mag_code = 3'd6 + {2'b00, round_up};
        end
        code.sign = sign & (mag_code != 3'd0);
        code.exp  = mag_code[2:1];
        code.man  = mag_code[0];
    end

endmodule

// File: rtl/fp4_e2m1_block_quantizer.sv
// Streaming MX-style block quantizer: buffers BLOCK_SIZE integers, derives a
// shared E8M0 scale from the OR of magnitudes, then streams E2M1 codes.
module fp4_e2m1_block_quantizer
    import fp4_e2m1_pkg::*;
#(
    parameter int BLOCK_SIZE = 32,
    parameter int IN_W       = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [IN_W-1:0] in_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [3:0]      out_code_o,
    output logic [7:0]      out_scale_o,
    output logic            out_last_o
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam int PW    = $clog2(IN_W);
    localparam int XW    = $clog2(IN_W) + 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_SIZE - 1);

    state_t                 state_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [IN_W-1:0]        or_acc_reg;
    logic signed [XW-1:0]   x_reg;
    logic [7:0]             scale_reg;

    logic [IN_W-1:0]        mag_mem [BLOCK_SIZE];
    logic                   sign_mem [BLOCK_SIZE];

    logic [IN_W-1:0]        in_mag;
    logic                   in_sign;
    logic                   in_fire;
    logic                   out_fire;
    logic                   idx_last;
    logic [PW-1:0]          msb_idx;
    int                     x_int;
    logic signed [XW-1:0]   x_next;
    logic [7:0]             scale_next;
    fp4_e2m1_t              enc_code;

    // Handshake and output decode; codes are forced to zero outside EMIT.
    always_comb begin
        in_ready_o  = (state_reg == ST_FILL);
        out_valid_o = (state_reg == ST_EMIT);
        idx_last    = (idx_reg == IDX_LAST);
        out_last_o  = out_valid_o && idx_last;
        in_fire     = in_valid_i && in_ready_o;
        out_fire    = out_valid_o && out_ready_i;
        out_code_o  = out_valid_o ? enc_code : 4'h0;
        out_scale_o = scale_reg;
        in_sign     = in_data_i[IN_W-1];
        in_mag      = in_sign ? (~in_data_i + 1'b1) : in_data_i;
    end

    // Highest set bit of the block OR gives the shared exponent X = p - emax.
    always_comb begin
        msb_idx = '0;
        for (int b = 0; b < IN_W; b++) begin
            if (or_acc_reg[b]) begin
                msb_idx = PW'(b);
            end
        end
        if (or_acc_reg == '0) begin
            x_int      = 0;
            scale_next = E8M0_ZERO_BLOCK;
        end else begin
            x_int      = int'(msb_idx) - E2M1_EMAX;
            scale_next = 8'(x_int) + E8M0_BIAS;
        end
        x_next = XW'(x_int);
    end

    // Element buffer: plain storage, contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mag_mem[idx_reg]  <= in_mag;
            sign_mem[idx_reg] <= in_sign;
        end
    end

    fp4_e2m1_encode #(
        .IN_W (IN_W),
        .XW   (XW)
    ) u_encode (
        .mag  (mag_mem[idx_reg]),
        .sign (sign_mem[idx_reg]),
        .x    (x_reg),
        .code (enc_code)
    );

    // Block sequencer: fill buffer, compute scale, drain codes, repeat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= '0;
            or_acc_reg <= '0;
            x_reg      <= '0;
            scale_reg  <= E8M0_ZERO_BLOCK;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_reg <= ST_FILL;
                end
                ST_FILL: begin
                    if (in_fire) begin
                        or_acc_reg <= or_acc_reg | in_mag;
                        idx_reg    <= idx_reg + 1'b1;
                        if (idx_last) begin
                            state_reg <= ST_SCALE;
                        end
                    end
                end
                ST_SCALE: begin
                    x_reg     <= x_next;
                    scale_reg <= scale_next;
                    state_reg <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_fire) begin
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_last) begin
                            idx_reg    <= '0;
                            or_acc_reg <= '0;
                            state_reg  <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp4_e2m1_block_quantizer.sv
// Directed bench for the FP4 block quantizer: hand-computed blocks covering
// zero, rounding ties, extreme magnitude, backpressure, reset mid-block and
// back-to-back blocks.
module tb_fp4_e2m1_block_quantizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_code;
    logic [7:0]  out_scale;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    logic [15:0] blk_in   [32];
    logic [3:0]  exp_code [32];
    logic [7:0]  exp_scale;

    fp4_e2m1_block_quantizer #(
        .BLOCK_SIZE (32),
        .IN_W       (16)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_code_o  (out_code),
        .out_scale_o (out_scale),
        .out_last_o  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: zero, 1: rounding, 2: extreme, 3: small (negative X)
    task automatic load_block(input int kind);
        for (int i = 0; i < 32; i++) begin
            blk_in[i]   = 16'h0000;
            exp_code[i] = 4'h0;
        end
        exp_scale = 8'h7F;
        case (kind)
            1: begin
                blk_in[0] = 16'd96;   exp_code[0] = 4'h7;
                blk_in[1] = 16'hFFF0; exp_code[1] = 4'hA;
                blk_in[2] = 16'd40;   exp_code[2] = 4'h4;
                blk_in[3] = 16'd4;    exp_code[3] = 4'h0;
                blk_in[4] = 16'd12;   exp_code[4] = 4'h2;
                blk_in[5] = 16'hFFB0; exp_code[5] = 4'hE;
                blk_in[6] = 16'd112;  exp_code[6] = 4'h7;
                exp_scale = 8'h83;
            end
            2: begin
                for (int i = 1; i < 32; i++) blk_in[i] = 16'd1;
                blk_in[0]   = 16'h8000;
                exp_code[0] = 4'hE;
                exp_scale   = 8'h8C;
            end
            3: begin
                blk_in[0] = 16'd3;    exp_code[0] = 4'h7;
                blk_in[1] = 16'hFFFF; exp_code[1] = 4'hC;
                blk_in[2] = 16'd2;    exp_code[2] = 4'h6;
                exp_scale = 8'h7E;
            end
            default: begin
            end
        endcase
    endtask

    // Push the loaded block; in_valid stays high afterwards.
    task automatic feed();
        int budget;
        for (int i = 0; i < 32; i++) begin
            budget   = 300;
            in_valid = 1'b1;
            in_data  = blk_in[i];
            while (!in_ready && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (budget == 0) chk("feed_timeout", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        chk("scale_cycle_valid", {31'd0, out_valid}, 32'd0);
        chk("scale_cycle_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Drain n codes, optionally toggling out_ready every cycle.
    task automatic collect(input int n, input bit stall);
        int i;
        int budget;
        bit tog;
        i = 0;
        budget = 400;
        tog = 1'b0;
        while (i < n && budget > 0) begin
            out_ready = stall ? tog : 1'b1;
            tog = ~tog;
            #1;
            if (out_valid) begin
                $display("emit elem %0d code %0h scale %0h last %0b ready %0b",
                         i, out_code, out_scale, out_last, out_ready);
                chk("code", {28'd0, out_code}, {28'd0, exp_code[i]});
                chk("last", {31'd0, out_last}, (i == 31) ? 32'd1 : 32'd0);
                chk("scale", {24'd0, out_scale}, {24'd0, exp_scale});
                chk("in_ready_during_emit", {31'd0, in_ready}, 32'd0);
                if (out_ready) i++;
            end
            @(negedge clk);
            budget--;
        end
        chk("collect_count", i, n);
        out_ready = 1'b0;
        if (n == 32) begin
            chk("in_ready_after_last", {31'd0, in_ready}, 32'd1);
            chk("valid_after_last", {31'd0, out_valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_out_code", {28'd0, out_code}, 32'd0);
        chk("rst_out_scale", {24'd0, out_scale}, 32'h7F);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_in_ready", {31'd0, in_ready}, 32'd1);

        // Zero block
        load_block(0);
        feed();
        collect(32, 1'b0);

        // Rounding block under toggling backpressure
        load_block(1);
        feed();
        collect(32, 1'b1);

        // Extreme magnitude
        load_block(2);
        feed();
        collect(32, 1'b0);

        // Back-to-back: in_valid stays high; second scale independent
        load_block(1);
        feed();
        in_data = 16'd3;
        collect(32, 1'b0);
        load_block(3);
        feed();
        collect(32, 1'b0);

        // Reset in the middle of EMIT
        load_block(1);
        feed();
        collect(10, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_code", {28'd0, out_code}, 32'd0);
        chk("midrst_out_scale", {24'd0, out_scale}, 32'h7F);
        chk("midrst_out_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load_block(3);
        feed();
        collect(32, 1'b0);

        in_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
